// File: rtl/kfpga_config_pkg.sv
// Shared configuration-chain types and helpers for the kfpga tile tops.
package kfpga_config_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    APPLY = 2'd2
  } cfg_state_t;

  // Widest chain any tile may present; narrower chains are zero-extended.
  localparam int CHAIN_MAX = 1024;

  function automatic logic chain_parity(input logic [CHAIN_MAX-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/io_crossbar.sv
// Pad/track AND-OR routing crossbar, outputs held low until a configuration is committed.
module io_crossbar #(
  parameter int IO_PADS   = 4,
  parameter int IC_TRACKS = 6
) (
  input  logic [IO_PADS*IC_TRACKS-1:0] active,
  input  logic                         valid,
  input  logic [IO_PADS-1:0]           data_from_io,
  input  logic [IC_TRACKS-1:0]         data_from_ic,
  output logic [IO_PADS-1:0]           data_to_io,
  output logic [IC_TRACKS-1:0]         data_to_ic
);

  logic [IO_PADS-1:0]   to_io_raw;
  logic [IC_TRACKS-1:0] to_ic_raw;

  // Bit p*IC_TRACKS+t connects pad p with track t in both directions.
  always_comb begin
    to_io_raw = '0;
    to_ic_raw = '0;
    for (int p = 0; p < IO_PADS; p++) begin
      for (int t = 0; t < IC_TRACKS; t++) begin
        to_io_raw[p] = to_io_raw[p] | (active[p*IC_TRACKS+t] & data_from_ic[t]);
        to_ic_raw[t] = to_ic_raw[t] | (active[p*IC_TRACKS+t] & data_from_io[p]);
      end
    end
  end

  assign data_to_io = valid ? to_io_raw : '0;
  assign data_to_ic = valid ? to_ic_raw : '0;

endmodule

// File: rtl/io_tile_shadow_top.sv
// IO tile: serial config chain segment, parity-checked shadow->active commit, routing crossbar.
//   state | meaning
//   IDLE  | chain may shift; a commit without shift enable starts a check
//   CHECK | parity of the frozen chain is judged; failure returns here with error
//   APPLY | shadow bits copied into the active register
import kfpga_config_pkg::*;

module io_tile_shadow_top #(
  parameter int IO_PADS   = 4,
  parameter int IC_TRACKS = 6
) (
  input  logic                 config_clock,
  input  logic                 config_nreset,
  input  logic                 config_in,
  output logic                 config_out,
  input  logic                 config_enable,
  input  logic                 config_commit,
  output logic                 config_busy,
  output logic                 config_valid,
  output logic                 config_error,
  input  logic [IO_PADS-1:0]   data_from_io,
  output logic [IO_PADS-1:0]   data_to_io,
  input  logic [IC_TRACKS-1:0] data_from_ic,
  output logic [IC_TRACKS-1:0] data_to_ic
);

  localparam int CONFIG_WIDTH = IO_PADS * IC_TRACKS;
  localparam int CHAIN_WIDTH  = CONFIG_WIDTH + 1;

  cfg_state_t              state, state_next;
  logic [CHAIN_WIDTH-1:0]  sr;
  logic [CONFIG_WIDTH-1:0] active;
  logic                    parity_ok;
  logic                    shift_en, capture, fail, apply;

  always_ff @(posedge config_clock) begin
    if (!config_nreset) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (config_commit && !config_enable) state_next = CHECK;
      CHECK:   state_next = parity_ok ? APPLY : IDLE;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    config_busy = (state != IDLE);
    shift_en    = (state == IDLE) && config_enable;
    capture     = (state == IDLE) && config_commit && !config_enable;
    fail        = (state == CHECK) && !parity_ok;
    apply       = (state == APPLY);
  end

  // Reset has priority over APPLY, so an interrupted commit never touches active.
  always_ff @(posedge config_clock) begin
    if (!config_nreset) begin
      sr           <= '0;
      active       <= '0;
      parity_ok    <= 1'b0;
      config_valid <= 1'b0;
      config_error <= 1'b0;
    end else begin
      if (shift_en) sr <= {sr[CHAIN_WIDTH-2:0], config_in};
      if (capture)  parity_ok <= chain_parity(CHAIN_MAX'(sr));
      if (fail)     config_error <= 1'b1;
      if (apply) begin
        active       <= sr[CONFIG_WIDTH-1:0];
        config_valid <= 1'b1;
        config_error <= 1'b0;
      end
    end
  end

  assign config_out = sr[CHAIN_WIDTH-1];

  io_crossbar #(
    .IO_PADS  (IO_PADS),
    .IC_TRACKS(IC_TRACKS)
  ) u_xbar (
    .active      (active),
    .valid       (config_valid),
    .data_from_io(data_from_io),
    .data_from_ic(data_from_ic),
    .data_to_io  (data_to_io),
    .data_to_ic  (data_to_ic)
  );

endmodule

// File: tb/tb_io_tile_shadow_top.sv
// Randomized self-checking bench for io_tile_shadow_top against a behavioural chain/commit model.
module tb_io_tile_shadow_top;

  logic       clk = 1'b0;
  logic       nrst, cin, cen, ccommit;
  logic       cout, busy, valid, err;
  logic [3:0] from_io, to_io;
  logic [5:0] from_ic, to_ic;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: chain contents, committed routing, status flags.
  logic [24:0] m_sr;
  logic [23:0] m_act;
  logic        m_valid, m_err;

  io_tile_shadow_top #(.IO_PADS(4), .IC_TRACKS(6)) dut (
    .config_clock (clk),
    .config_nreset(nrst),
    .config_in    (cin),
    .config_out   (cout),
    .config_enable(cen),
    .config_commit(ccommit),
    .config_busy  (busy),
    .config_valid (valid),
    .config_error (err),
    .data_from_io (from_io),
    .data_to_io   (to_io),
    .data_from_ic (from_ic),
    .data_to_ic   (to_ic)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_to_io(logic [23:0] act, logic v, logic [5:0] ic);
    logic [3:0] r = '0;
    if (v)
      for (int p = 0; p < 4; p++)
        for (int t = 0; t < 6; t++)
          if (act[p*6+t] && ic[t]) r[p] = 1'b1;
    return r;
  endfunction

  function automatic logic [5:0] ref_to_ic(logic [23:0] act, logic v, logic [3:0] io);
    logic [5:0] r = '0;
    if (v)
      for (int t = 0; t < 6; t++)
        for (int p = 0; p < 4; p++)
          if (act[p*6+t] && io[p]) r[t] = 1'b1;
    return r;
  endfunction

  function automatic logic [24:0] rand_word(bit odd);
    logic [24:0] w;
    w[23:0] = 24'($urandom);
    w[24]   = odd ? ~(^w[23:0]) : (^w[23:0]);
    return w;
  endfunction

  task automatic shift_bit(logic b, logic com);
    cin = b; cen = 1'b1; ccommit = com;
    step();
    m_sr = {m_sr[23:0], b};
    cen = 1'b0; ccommit = 1'b0;
  endtask

  task automatic shift_word(logic [24:0] w);
    for (int i = 24; i >= 0; i--) shift_bit(w[i], 1'b0);
  endtask

  task automatic check_xbar(string tag);
    for (int i = 0; i < 4; i++) begin
      from_io = 4'($urandom);
      from_ic = 6'($urandom);
      #1;
      n_cmp++;
      if (to_io !== ref_to_io(m_act, m_valid, from_ic)) begin
        n_bad++;
        $display("FAIL %s to_io: got %b want %b (from_ic=%b)", tag, to_io,
                 ref_to_io(m_act, m_valid, from_ic), from_ic);
      end
      n_cmp++;
      if (to_ic !== ref_to_ic(m_act, m_valid, from_io)) begin
        n_bad++;
        $display("FAIL %s to_ic: got %b want %b (from_io=%b)", tag, to_ic,
                 ref_to_ic(m_act, m_valid, from_io), from_io);
      end
    end
  endtask

  // Pulse commit; optionally wiggle enable/in/commit while busy to prove the chain is frozen.
  task automatic do_commit(string tag, bit wiggle);
    logic ok;
    ok = ^m_sr;
    cen = 1'b0; ccommit = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy@k: got %b want 1", tag, busy); end
    cen = wiggle ? 1'($urandom) : 1'b0;
    cin = 1'($urandom);
    ccommit = wiggle ? 1'b1 : 1'b0;
    step();
    if (!ok) begin
      m_err = 1'b1;
      cen = 1'b0; ccommit = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0 || valid !== m_valid) begin
        n_bad++;
        $display("FAIL %s reject: err=%b busy=%b valid=%b want 1 0 %b", tag, err, busy, valid, m_valid);
      end
    end else begin
      n_cmp++;
      if (busy !== 1'b1 || valid !== m_valid) begin
        n_bad++;
        $display("FAIL %s check@k+1: busy=%b valid=%b want 1 %b", tag, busy, valid, m_valid);
      end
      cen = wiggle ? 1'b1 : 1'b0;
      cin = 1'($urandom);
      step();
      cen = 1'b0; ccommit = 1'b0;
      m_act = m_sr[23:0]; m_valid = 1'b1; m_err = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || valid !== 1'b1 || err !== 1'b0) begin
        n_bad++;
        $display("FAIL %s apply@k+2: busy=%b valid=%b err=%b want 0 1 0", tag, busy, valid, err);
      end
    end
    n_cmp++;
    if (cout !== m_sr[24]) begin
      n_bad++;
      $display("FAIL %s frozen config_out: got %b want %b", tag, cout, m_sr[24]);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cin = 1'($urandom); cen = 1'($urandom); ccommit = 1'($urandom);
      from_io = 4'($urandom); from_ic = 6'($urandom);
      step();
    end
    m_sr = '0; m_act = '0; m_valid = 1'b0; m_err = 1'b0;
    from_io = 4'hF; from_ic = 6'h3F;
    #1;
    n_cmp++;
    if ({cout, busy, valid, err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset status: got %b want 0000", {cout, busy, valid, err});
    end
    n_cmp++;
    if (to_ic !== 6'd0 || to_io !== 4'd0) begin
      n_bad++;
      $display("FAIL reset xbar: to_ic=%b to_io=%b want 0", to_ic, to_io);
    end
    cen = 1'b0; ccommit = 1'b0; cin = 1'b0;
    nrst = 1'b1;
    step();
  endtask

  task automatic test_shift();
    logic hist [50];
    for (int i = 0; i < 50; i++) begin
      hist[i] = 1'($urandom);
      shift_bit(hist[i], 1'b0);
      if (i >= 24) begin
        n_cmp++;
        if (cout !== hist[i-24]) begin
          n_bad++;
          $display("FAIL shift delay bit %0d: got %b want %b", i - 24, cout, hist[i-24]);
        end
      end
    end
  endtask

  task automatic test_good_commit();
    m_sr = m_sr;
    shift_word({1'b1, 24'h800001});
    do_commit("good", 1'b0);
    from_ic = 6'b100001; #1;
    n_cmp++;
    if (to_io !== 4'b1001) begin n_bad++; $display("FAIL good to_io: got %b want 1001", to_io); end
    from_io = 4'b0001; #1;
    n_cmp++;
    if (to_ic !== 6'b000001) begin n_bad++; $display("FAIL good to_ic: got %b want 000001", to_ic); end
    check_xbar("good_rand");
  endtask

  task automatic test_bad_parity();
    shift_word(rand_word(1'b0));
    do_commit("bad", 1'b0);
    check_xbar("bad_unchanged");
    step(); step();
    n_cmp++;
    if (err !== 1'b1 || valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bad sticky: err=%b valid=%b want 1 1", err, valid);
    end
    shift_word(rand_word(1'b1));
    do_commit("recover", 1'b0);
    check_xbar("recover");
  endtask

  task automatic test_priority_freeze();
    logic [24:0] w;
    w = rand_word(1'b1);
    for (int i = 24; i >= 1; i--) shift_bit(w[i], 1'b0);
    shift_bit(w[0], 1'b1);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL priority busy: got %b want 0", busy); end
    step();
    n_cmp++;
    if (busy !== 1'b0 || cout !== m_sr[24]) begin
      n_bad++;
      $display("FAIL priority idle: busy=%b out=%b want 0 %b", busy, cout, m_sr[24]);
    end
    do_commit("freeze", 1'b1);
    check_xbar("freeze");
    shift_word(rand_word(1'b0));
    do_commit("freeze_bad", 1'b1);
  endtask

  task automatic test_reset_mid_commit();
    shift_word(rand_word(1'b1));
    cen = 1'b0; ccommit = 1'b1;
    step();
    ccommit = 1'b0;
    step();
    nrst = 1'b0;
    step();
    m_sr = '0; m_act = '0; m_valid = 1'b0; m_err = 1'b0;
    n_cmp++;
    if ({cout, busy, valid, err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL midreset status: got %b want 0000", {cout, busy, valid, err});
    end
    nrst = 1'b1;
    check_xbar("midreset");
    step();
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset after: busy=%b valid=%b want 0 0", busy, valid);
    end
    shift_word(rand_word(1'b1));
    do_commit("post_reset", 1'b0);
    check_xbar("post_reset");
  endtask

  initial begin
    nrst = 1'b0; cin = 1'b0; cen = 1'b0; ccommit = 1'b0;
    from_io = '0; from_ic = '0;
    m_sr = '0; m_act = '0; m_valid = 1'b0; m_err = 1'b0;
    test_reset();
    test_shift();
    test_good_commit();
    test_bad_parity();
    test_priority_freeze();
    test_reset_mid_commit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_tile_shadow_top.md
# io_tile_shadow_top

Parametrised successor to the fixed 4-pad/6-track south IO tile top. It holds a serial configuration chain segment plus a double-buffered (shadow/active) configuration register. A parity-checked commit handshake transfers the shifted bits into the routing crossbar between pads and interconnect tracks. It is used for all four fabric edges; one instance per IO tile, chained through `config_in`/`config_out`.

## Interface
Parameters:
- `IO_PADS`, default 4: pads served by the tile.
- `IC_TRACKS`, default 6: interconnect tracks at the tile edge.
- `CONFIG_WIDTH`, derived as `IO_PADS*IC_TRACKS`: routing bits. Not overridable.
- `CHAIN_WIDTH`, derived as `CONFIG_WIDTH+1`: routing bits plus one parity bit.

Ports:
- `config_clock` in 1: sole clock. One clock; all state updates on its rising edge.
- `config_nreset` in 1: reset, synchronous, active-low.
- `config_in` in 1: serial chain input.
- `config_out` in 1→out: serial chain output, equal to `sr[CHAIN_WIDTH-1]`.
- `config_enable` in 1: shift enable.
- `config_commit` in 1: commit request, level-sampled.
- `config_busy` out 1: commit in progress.
- `config_valid` out 1: active register holds a committed configuration.
- `config_error` out 1: last commit failed the parity check (sticky).
- `data_from_io` in `IO_PADS`.
- `data_to_io` out `IO_PADS`.
- `data_from_ic` in `IC_TRACKS`.
- `data_to_ic` out `IC_TRACKS`.

## Operation
Chain register `sr[CHAIN_WIDTH-1:0]`:
- Shifts on each clock edge when `config_enable`=1 and state is IDLE: `sr <= {sr[CHAIN_WIDTH-2:0], config_in}`.
- `sr[CHAIN_WIDTH-1]` is the parity bit; `sr[CONFIG_WIDTH-1:0]` is the shadow configuration.
- Parity rule: the commit is accepted when the XOR of all `CHAIN_WIDTH` bits is 1 (odd parity). An all-zero chain is therefore rejected.

State machine (IDLE, CHECK, APPLY):
- IDLE → CHECK when `config_commit`=1 and `config_enable`=0. Registers `parity_ok`.
- A commit with `config_enable`=1 is ignored; the shift takes priority.
- CHECK → APPLY if `parity_ok`. Otherwise CHECK → IDLE, setting `config_error`=1. Active register and `config_valid` are unchanged on failure.
- APPLY → IDLE, with `active <= sr[CONFIG_WIDTH-1:0]`, `config_valid`=1, `config_error`=0.
- In CHECK and APPLY, `config_enable` and `config_commit` are ignored, so `sr` is frozen.
- `config_busy` = (state != IDLE).

Crossbar (combinational from `active`), bit index `b = p*IC_TRACKS + t`:
- `data_to_io[p]` = OR over t of (`active[b]` & `data_from_ic[t]`).
- `data_to_ic[t]` = OR over p of (`active[b]` & `data_from_io[p]`).
- While `config_valid`=0, both outputs are forced to 0.

Reset values (when `config_nreset`=0 at an edge):
- `sr`, `active`, `parity_ok` = 0; state = IDLE.
- Outputs `config_out`, `config_busy`, `config_valid`, `config_error`, `data_to_io`, `data_to_ic` = 0.
- Reset aborts an in-progress commit: `active` is never partially written.

## Timing
- Shift latency: a bit presented on `config_in` at edge k appears on `config_out` after edge k+`CHAIN_WIDTH`-1. Chain throughput is 1 bit/cycle.
- Commit sampled at edge k:
  - `config_busy`=1 after edge k.
  - On failure: `config_error` is set after edge k+1, and `busy` drops after edge k+1.
  - On success: `active`/`config_valid` update after edge k+2, and `busy` drops after edge k+2.
- A commit held high re-triggers on the first IDLE edge after APPLY (level-sensitive). Controllers pulse it for one cycle.
- `config_commit` is driven globally to all tiles in the chain. Every tile checks its own segment independently.
- Data path: zero-cycle combinational paths through the crossbar. No register between `data_from_*` and `data_to_*`.

## Structure
- Shared package `kfpga_config_pkg`:
  - State enum `cfg_state_t` {IDLE, CHECK, APPLY}.
  - Parity function `chain_parity`.
- One sub-module, `io_crossbar`, parametrised by `IO_PADS`/`IC_TRACKS`. It implements the AND-OR routing plus the valid gating.
- Top: chain register, FSM, active register, output assignment.

## Test plan
All with defaults (4/6, `CHAIN_WIDTH`=25).
- **Reset:** hold `config_nreset`=0 two cycles with random inputs → all outputs 0. `data_from_io`=4'hF → `data_to_ic`=0.
- **Shift passthrough:** 50 random bits with enable=1 → `config_out` reproduces the input delayed exactly 24 cycles. `sr` holds the last 25 bits.
- **Good commit:** shift in bits so that `active[0]` (pad 0/track 0) and `active[23]` (pad 3/track 5) are 1, others 0, parity bit 1 (XOR of the 25 bits = 1); then pulse commit.
  - `busy` is high for 2 cycles; `valid`=1 after commit edge+2.
  - `data_from_ic`=6'b100001 → `data_to_io`=4'b1001.
  - `data_from_io`=4'b0001 → `data_to_ic`=6'b000001.
- **Bad parity:** after the good commit, shift a pattern with even parity and commit.
  - `config_error`=1 after commit edge+1; `valid` stays 1; crossbar is unchanged.
  - A following good commit clears the error.
- **Priority/freeze:** assert commit together with enable=1 → no commit, `busy`=0. Then toggle enable during CHECK/APPLY → `sr` and `config_out` are unchanged.
- **Reset mid-commit:** deassert `config_nreset` on the cycle the state enters APPLY → `active`=0, `valid`=0, IDLE, no partial update.
